// File: rtl/pdp1_term_pkg.sv
// Shared command encodings and controller state type for the PDP-1 terminal
// scroll frame buffer.
package pdp1_term_pkg;

    localparam logic [1:0] CMD_PUT       = 2'd0;
    localparam logic [1:0] CMD_NEWLINE   = 2'd1;
    localparam logic [1:0] CMD_CLEAR     = 2'd2;
    localparam logic [1:0] CMD_BACKSPACE = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_ALL
    } state_t;

endpackage

// File: rtl/pdp1_term_ram.sv
// Simple dual-port character RAM: one write port, one registered read port,
// read-first on a same-address collision.
module pdp1_term_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset so it maps onto block RAM; the
    // controller's clear sequence is what blanks it.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // Sampling mem on the same edge as the write returns the old word.
    always_ff @(posedge clock) begin
        if (!reset_n) q <= '0;
        else          q <= mem[raddr];
    end

endmodule

// File: rtl/pdp1_terminal_scroll_fb.sv
// Teletype screen buffer with cursor, auto-wrap, rotating-top scroll and
// hardware clears. Optional read-side cursor flag: PDP1_TERM_FB_CURSOR_EN.
module pdp1_terminal_scroll_fb
    import pdp1_term_pkg::*;
#(
    parameter int                 CHAR_W   = 8,
    parameter int                 COL_BITS = 6,
    parameter int                 ROW_BITS = 5,
    parameter logic [CHAR_W-1:0]  BLANK    = 8'h00
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                char_valid,
    output logic                char_ready,
    input  logic [1:0]          char_cmd,
    input  logic [CHAR_W-1:0]   char_data,
    input  logic [ROW_BITS-1:0] rd_row,
    input  logic [COL_BITS-1:0] rd_col,
    output logic [CHAR_W-1:0]   rd_q,
    output logic                rd_cursor,
    output logic [ROW_BITS-1:0] cursor_row,
    output logic [COL_BITS-1:0] cursor_col,
    output logic                busy
);

    localparam int                  ADDR_W    = ROW_BITS + COL_BITS;
    localparam logic [ROW_BITS-1:0] ROW_LAST  = '1;
    localparam logic [COL_BITS-1:0] COL_LAST  = '1;
    localparam logic [ADDR_W-1:0]   ADDR_LAST = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;
    logic [ROW_BITS-1:0] top_q, top_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;

    logic                newline;
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [CHAR_W-1:0]   wdata;
    logic [ROW_BITS-1:0] cur_phys_row;
    logic [ROW_BITS-1:0] bottom_phys_row;
    logic [ROW_BITS-1:0] rd_phys_row;

    assign char_ready      = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign cursor_row      = row_q;
    assign cursor_col      = col_q;
    assign cur_phys_row    = row_q + top_q;
    assign bottom_phys_row = top_q + ROW_LAST;
    assign rd_phys_row     = rd_row + top_q;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        top_d   = top_q;
        row_d   = row_q;
        col_d   = col_q;
        newline = 1'b0;
        we      = 1'b0;
        waddr   = {cur_phys_row, col_q};
        wdata   = char_data;

        case (state_q)
            IDLE: begin
                if (char_valid) begin
                    case (char_cmd)
                        CMD_PUT: begin
                            we = 1'b1;
                            if (col_q == COL_LAST) newline = 1'b1;
                            else                   col_d   = col_q + 1'b1;
                        end
                        CMD_NEWLINE: newline = 1'b1;
                        CMD_BACKSPACE: begin
                            if (col_q != '0) col_d = col_q - 1'b1;
                        end
                        default: begin
                            state_d = CLR_ALL;
                            clr_d   = '0;
                        end
                    endcase
                end
                if (newline) begin
                    col_d = '0;
                    if (row_q != ROW_LAST) begin
                        row_d = row_q + 1'b1;
                    end else begin
                        // Scroll: the old top physical row becomes the new bottom.
                        top_d   = top_q + 1'b1;
                        state_d = CLR_LINE;
                        clr_d   = '0;
                    end
                end
            end
            CLR_LINE: begin
                we    = 1'b1;
                waddr = {bottom_phys_row, clr_q[COL_BITS-1:0]};
                wdata = BLANK;
                clr_d = clr_q + 1'b1;
                if (clr_q[COL_BITS-1:0] == COL_LAST) state_d = IDLE;
            end
            CLR_ALL: begin
                we    = 1'b1;
                waddr = clr_q;
                wdata = BLANK;
                clr_d = clr_q + 1'b1;
                if (clr_q == ADDR_LAST) begin
                    state_d = IDLE;
                    top_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            default: begin
                state_d = CLR_ALL;
                clr_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= CLR_ALL;
            clr_q   <= '0;
            top_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            top_q   <= top_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    pdp1_term_ram #(
        .DATA_W (CHAR_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (we && reset_n),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   ({rd_phys_row, rd_col}),
        .q       (rd_q)
    );

`ifdef PDP1_TERM_FB_CURSOR_EN
    always_ff @(posedge clock) begin
        if (!reset_n) rd_cursor <= 1'b0;
        else          rd_cursor <= (rd_row == row_q) && (rd_col == col_q);
    end
`else
    assign rd_cursor = 1'b0;
`endif

endmodule

// File: tb/tb_pdp1_terminal_scroll_fb.sv
// Self-checking bench for pdp1_terminal_scroll_fb against a logical-screen model
// (rows shift up on scroll); honours PDP1_TERM_FB_CURSOR_EN for rd_cursor.
module tb_pdp1_terminal_scroll_fb;

    localparam int ROWS = 32;
    localparam int COLS = 64;
    localparam int CELLS = ROWS * COLS;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       char_valid = 1'b0;
    logic [1:0] char_cmd = 2'd0;
    logic [7:0] char_data = 8'h00;
    logic [4:0] rd_row = '0;
    logic [5:0] rd_col = '0;
    logic       char_ready;
    logic [7:0] rd_q;
    logic       rd_cursor;
    logic [4:0] cursor_row;
    logic [5:0] cursor_col;
    logic       busy;

    always #5 clock = ~clock;

    pdp1_terminal_scroll_fb dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_cmd   (char_cmd),
        .char_data  (char_data),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_q       (rd_q),
        .rd_cursor  (rd_cursor),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_pass = 0;

    // Logical screen model: scr[row][col], row 0 = top of screen.
    logic [7:0] scr [ROWS][COLS];
    int crow = 0;
    int ccol = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
        crow = 0;
        ccol = 0;
    endtask

    task automatic model_newline();
        ccol = 0;
        if (crow < ROWS - 1) begin
            crow++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
        end
    endtask

    task automatic model_apply(input logic [1:0] cmd, input logic [7:0] d);
        case (cmd)
            2'd0: begin
                scr[crow][ccol] = d;
                if (ccol == COLS - 1) model_newline();
                else ccol++;
            end
            2'd1: model_newline();
            2'd2: model_clear();
            default: if (ccol > 0) ccol--;
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!char_ready && n < budget) begin
            tick();
            n++;
        end
        if (!char_ready) check("ready_timeout", {31'd0, char_ready}, 32'd1);
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_row"}, {27'd0, cursor_row}, crow);
        check({tag, "_col"}, {26'd0, cursor_col}, ccol);
    endtask

    task automatic send(input logic [1:0] cmd, input logic [7:0] d);
        wait_ready(5000);
        char_valid = 1'b1;
        char_cmd   = cmd;
        char_data  = d;
        tick();
        char_valid = 1'b0;
        model_apply(cmd, d);
        if (cmd == 2'd2) wait_ready(5000);
        check_cursor("cursor");
    endtask

    task automatic read_cell(input int r, input int c);
        logic exp_cur;
        wait_ready(5000);
        rd_row = r[4:0];
        rd_col = c[5:0];
        tick();
        check($sformatf("rd_q(%0d,%0d)", r, c), {24'd0, rd_q}, {24'd0, scr[r][c]});
`ifdef PDP1_TERM_FB_CURSOR_EN
        exp_cur = (r == crow) && (c == ccol);
`else
        exp_cur = 1'b0;
`endif
        check($sformatf("rd_cursor(%0d,%0d)", r, c), {31'd0, rd_cursor}, {31'd0, exp_cur});
    endtask

    task automatic check_screen();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) read_cell(r, c);
    endtask

    // Count cycles from now until char_ready rises (bounded).
    task automatic count_busy(input string tag, input int exp_cycles);
        int n = 0;
        while (!char_ready && n < exp_cycles + 200) begin
            tick();
            n++;
        end
        check(tag, n, exp_cycles);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] last_ch;
        int sel;

        model_clear();

        // Reset held 3 cycles.
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 1);
        check("rst_ready", {31'd0, char_ready}, 0);
        check("rst_rd_q", {24'd0, rd_q}, 0);
        check("rst_rd_cursor", {31'd0, rd_cursor}, 0);
        check_cursor("rst_cursor");
        reset_n = 1'b1;
        count_busy("init_clear_len", CELLS);
        check_screen();

        // PUT 'A' at (0,0).
        send(2'd0, 8'h41);
        read_cell(0, 0);

        // 64 PUTs on row 5 wrap to (6,0).
        repeat (5) send(2'd1, 8'h00);
        last_ch = 8'h00;
        for (int i = 0; i < COLS; i++) begin
            last_ch = 8'($urandom_range(255));
            send(2'd0, last_ch);
        end
        read_cell(5, COLS - 1);
        check("row5_col63_last", {24'd0, rd_q}, {24'd0, last_ch});

        // Same-cycle read and write of (2,3): read-first.
        send(2'd2, 8'h00);
        repeat (2) send(2'd1, 8'h00);
        repeat (3) send(2'd0, 8'($urandom_range(255)));
        send(2'd0, 8'h41);
        send(2'd3, 8'h00);
        wait_ready(5000);
        rd_row = 5'd2;
        rd_col = 6'd3;
        char_valid = 1'b1;
        char_cmd = 2'd0;
        char_data = 8'h42;
        tick();
        char_valid = 1'b0;
        model_apply(2'd0, 8'h42);
        check("rw_same_old", {24'd0, rd_q}, 32'h41);
        tick();
        check("rw_same_new", {24'd0, rd_q}, 32'h42);

        // Scroll from the last row.
        for (int r = 0; r < ROWS; r++) begin
            send(2'd0, 8'(8'h60 + r));
            if (crow < ROWS - 1) send(2'd1, 8'h00);
        end
        wait_ready(5000);
        char_valid = 1'b1;
        char_cmd = 2'd1;
        tick();
        char_valid = 1'b0;
        model_apply(2'd1, 8'h00);
        check("scroll_ready_low", {31'd0, char_ready}, 0);
        check("scroll_busy", {31'd0, busy}, 1);
        check_cursor("scroll_cursor");
        count_busy("scroll_len", COLS);
        check_screen();

        // BACKSPACE at column 0 is a no-op.
        send(2'd2, 8'h00);
        repeat (4) send(2'd1, 8'h00);
        send(2'd3, 8'h00);
        read_cell(4, 0);
        read_cell(4, 1);
        read_cell(3, 0);

        // Randomized command stream with interleaved reads.
        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(99);
            if (sel < 70)      send(2'd0, 8'($urandom_range(255)));
            else if (sel < 85) send(2'd1, 8'h00);
            else if (sel < 99) send(2'd3, 8'h00);
            else               send(2'd2, 8'h00);
            read_cell($urandom_range(ROWS - 1), $urandom_range(COLS - 1));
            read_cell(crow, ccol);
        end
        check_screen();

        // Reset asserted mid-clear restarts the full clear.
        send(2'd0, 8'h55);
        send(2'd1, 8'h00);
        wait_ready(5000);
        char_valid = 1'b1;
        char_cmd = 2'd2;
        tick();
        char_valid = 1'b0;
        repeat (100) tick();
        reset_n = 1'b0;
        tick();
        model_clear();
        check("midrst_busy", {31'd0, busy}, 1);
        check("midrst_ready", {31'd0, char_ready}, 0);
        check_cursor("midrst_cursor");
        reset_n = 1'b1;
        count_busy("midrst_clear_len", CELLS);
        check_screen();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pdp1_terminal_scroll_fb.md
# pdp1_terminal_scroll_fb

Parametrised teletype-screen buffer with an integrated write controller. It accepts a character/command stream, maintains the cursor, auto-wraps, scrolls through a rotating top-row pointer, and hardware-clears lines or the whole screen. The display scan-out reads logical (row, column) positions through a 1-cycle read port. It sits between the teletype emulator's character source and the video character generator.

## Interface
- `CHAR_W`, 8, character width in bits
- `COL_BITS`, 6, log2 of columns (default 64)
- `ROW_BITS`, 5, log2 of rows (default 32)
- `BLANK`, 8'h00, fill value for cleared cells
- `clock`  in  1  sole clock; all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `char_valid`  in  1  command/character offered
- `char_ready`  out  1  block can accept this cycle
- `char_cmd`  in  2  0 PUT, 1 NEWLINE, 2 CLEAR, 3 BACKSPACE
- `char_data`  in  CHAR_W  character for PUT; ignored otherwise
- `rd_row`  in  ROW_BITS  logical row, 0 = top of screen
- `rd_col`  in  COL_BITS  column
- `rd_q`  out  CHAR_W  registered cell contents
- `rd_cursor`  out  1  registered: the read address equals the cursor
- `cursor_row`  out  ROW_BITS  logical cursor row
- `cursor_col`  out  COL_BITS  cursor column
- `busy`  out  1  clear sequence in progress

## Operation
- Storage: 2^(ROW_BITS+COL_BITS) cells. Physical row = (logical row + top) mod 2^ROW_BITS. `top` is a ROW_BITS register that wraps naturally.
- A transfer occurs when `char_valid && char_ready`. `char_ready` = (state == IDLE).
- PUT:
  - Write `char_data` at (physical(cursor_row), cursor_col).
  - Then col+1.
  - If col was the last column, perform NEWLINE semantics after the write.
- NEWLINE:
  - col = 0.
  - If row < last row: row+1.
  - Else: top+1 (row stays at last), then enter CLR_LINE to blank the new bottom physical row.
- BACKSPACE: col−1 if col > 0, else no-op. No write.
- CLEAR: enter CLR_ALL. On completion: top = 0, cursor = (0,0).
- States:
  - IDLE → CLR_LINE on a scroll.
  - IDLE → CLR_ALL on CLEAR.
  - CLR_LINE writes `BLANK` to columns 0..last of the target row, one per cycle, then returns to IDLE.
  - CLR_ALL writes `BLANK` to every cell in ascending physical address, one per cycle, then returns to IDLE.
- Reset enters CLR_ALL. Reset asserted mid-clear or mid-scroll restarts CLR_ALL from address 0.
- The read port is independent of state and always serviced, including during clears.
- Read/write to the same cell in the same cycle is read-first: `rd_q` returns the old value.

## Timing
- Reset values:
  - `rd_q` = 0, `rd_cursor` = 0
  - `cursor_row` = 0, `cursor_col` = 0, top = 0
  - `char_ready` = 0, `busy` = 1, state CLR_ALL at address 0
- After reset deasserts, the first `char_ready` comes 2^(ROW_BITS+COL_BITS) cycles later (2048 by default).
- Read latency is 1: address sampled at edge N, `rd_q`/`rd_cursor` valid after edge N. Physical mapping uses `top` at sample time.
- PUT accepted at edge N: RAM written at N; cursor outputs updated after N; `char_ready` stays 1.
- Scroll accepted at edge N: `char_ready` = 0 and `busy` = 1 for 2^COL_BITS cycles; `char_ready` returns after edge N + 2^COL_BITS.
- CLEAR accepted at edge N: busy for 2^(ROW_BITS+COL_BITS) cycles.
- Cursor, top and column arithmetic are unsigned and modulo the field width; no saturation except BACKSPACE at column 0.

## Configuration
- `PDP1_TERM_FB_CURSOR_EN`
  - Defined: `rd_cursor` is computed by comparing the sampled (rd_row, rd_col) against the cursor and registering the result alongside `rd_q`.
  - Undefined: `rd_cursor` is tied 0 and the compare logic is absent.
- All other behaviour is identical in both builds.

## Structure
- Package `pdp1_term_pkg` holds:
  - cmd encodings (CMD_PUT, CMD_NEWLINE, CMD_CLEAR, CMD_BACKSPACE)
  - the state enum (IDLE, CLR_LINE, CLR_ALL)
- Sub-module `pdp1_term_ram`: parametrised simple dual-port RAM, read-first, one write port, one registered read port, no reset on contents.
- The controller, address mapping and cursor logic live in the top module.

## Test plan
- Reset, hold `reset_n` low 3 cycles, release → `busy` = 1 for 2048 cycles, then `char_ready` = 1; every cell reads 8'h00.
- PUT 'A' (8'h41) at (0,0) → cursor (0,1); read (0,0) next cycle → `rd_q` = 8'h41.
- 64 PUTs on row 5 → cursor wraps to (6,0); row 5 col 63 holds the 64th character.
- Cursor at row 31, NEWLINE → `char_ready` low for exactly 64 cycles; old logical row 1 now reads at logical row 0; logical row 31 all 8'h00.
- Same-cycle read and write of cell (2,3), old 8'h41, new 8'h42 → `rd_q` = 8'h41; next read → 8'h42.
- BACKSPACE at (4,0) → cursor unchanged; with `PDP1_TERM_FB_CURSOR_EN`, reading (4,0) gives `rd_cursor` = 1, any other cell 0.
